// File: rtl/reg_file_pkg.sv
// Shared definitions for the reg_file storage block:
// write-op encodings and the address-width helper.
package reg_file_pkg;

   localparam logic [1:0] OP_HOLD = 2'd0;
   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_INC  = 2'd2;
   localparam logic [1:0] OP_DEC  = 2'd3;

   // Index width; never below one bit.
   function automatic int aw_f(input int depth);
      if (depth <= 2) return 1;
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/reg_file_next.sv
// Next-value and wrap computation for one register.
// Ports: cur_i/op_i/wdata_i in, nxt_o (next value) and wrap_o out.
module reg_file_next
   import reg_file_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] nxt_o,
   output logic             wrap_o
);

   always_comb begin
      nxt_o  = cur_i;
      wrap_o = 1'b0;
      unique case (op_i)
         OP_HOLD: nxt_o = cur_i;
         OP_LOAD: nxt_o = wdata_i;
         OP_INC: begin
            nxt_o  = cur_i + 1'b1;
            wrap_o = &cur_i;
         end
         OP_DEC: begin
            nxt_o  = cur_i - 1'b1;
            wrap_o = ~|cur_i;
         end
         default: nxt_o = cur_i;
      endcase
   end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one load/inc/dec write port,
// two combinational read ports, optional bypass, registered wrap.
// Ports: clk, clr (async active-low), we/op/waddr/wdata write,
// raddr_a/rdata_a and raddr_b/rdata_b reads, wrap flag out.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int              WIDTH     = 8,
   parameter int              DEPTH     = 4,
   parameter int              BYPASS    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int             AW        = aw_f(DEPTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [1:0]       op,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   output logic             wrap
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             wrap_q;
   logic             wrap_d;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nxt;
   logic             wrap_c;
   logic             wr_ok;
   logic             byp;
   logic [WIDTH-1:0] st_a;
   logic [WIDTH-1:0] st_b;

   assign wr_ok = we && (int'(waddr) < DEPTH);

   // Explicit compare muxes keep out-of-range indices at zero.
   always_comb begin
      cur  = '0;
      st_a = '0;
      st_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (waddr == AW'(i))   cur  = regs_q[i];
         if (raddr_a == AW'(i)) st_a = regs_q[i];
         if (raddr_b == AW'(i)) st_b = regs_q[i];
      end
   end

   reg_file_next #(.WIDTH(WIDTH)) u_next (
      .cur_i   (cur),
      .op_i    (op),
      .wdata_i (wdata),
      .nxt_o   (nxt),
      .wrap_o  (wrap_c)
   );

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_ok && waddr == AW'(i)) regs_d[i] = nxt;
      end
      wrap_d = wr_ok && wrap_c;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
         wrap_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         wrap_q <= wrap_d;
      end
   end

   // Bypass is gated by clr so reset contents show during reset.
   assign byp = (BYPASS != 0) && clr && wr_ok && (op != OP_HOLD);

   assign rdata_a = (byp && raddr_a == waddr) ? nxt : st_a;
   assign rdata_b = (byp && raddr_b == waddr) ? nxt : st_b;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: bypass, no-bypass and DEPTH=3
// instances share one stimulus stream.
module tb_reg_file;
   import reg_file_pkg::*;

   logic       clk = 1'b0;
   logic       clr;
   logic       we;
   logic [1:0] op;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;

   logic [7:0] a_d, b_d, a_n, b_n, a_3, b_3;
   logic       w_d, w_n, w_3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .RESET_VAL(8'h5A)) u_dut (
      .clk(clk), .clr(clr), .we(we), .op(op), .waddr(waddr),
      .wdata(wdata), .raddr_a(raddr_a), .rdata_a(a_d),
      .raddr_b(raddr_b), .rdata_b(b_d), .wrap(w_d)
   );

   reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .RESET_VAL(8'h5A)) u_nb (
      .clk(clk), .clr(clr), .we(we), .op(op), .waddr(waddr),
      .wdata(wdata), .raddr_a(raddr_a), .rdata_a(a_n),
      .raddr_b(raddr_b), .rdata_b(b_n), .wrap(w_n)
   );

   reg_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1), .RESET_VAL(8'h5A)) u_d3 (
      .clk(clk), .clr(clr), .we(we), .op(op), .waddr(waddr),
      .wdata(wdata), .raddr_a(raddr_a), .rdata_a(a_3),
      .raddr_b(raddr_b), .rdata_b(b_3), .wrap(w_3)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] o, input logic [1:0] ad,
                     input logic [7:0] d);
      we = 1'b1; op = o; waddr = ad; wdata = d;
      tick();
      we = 1'b0; op = OP_HOLD;
      #1;
   endtask

   initial begin
      clr = 1'b0; we = 1'b0; op = OP_HOLD; waddr = '0;
      wdata = '0; raddr_a = '0; raddr_b = '0;
      tick(); tick();
      clr = 1'b1;
      #1;
      chk("rst_a", a_d, 8'h5A);
      chk("rst_wrap", {7'd0, w_d}, 8'h00);

      wr(OP_LOAD, 2'd2, 8'h3C);
      raddr_a = 2'd2; raddr_b = 2'd1;
      #1;
      chk("load_a", a_d, 8'h3C);
      chk("load_b", b_d, 8'h5A);

      // async reset between edges
      clr = 1'b0;
      #1;
      chk("async_rst_a", a_d, 8'h5A);
      chk("async_rst_3", a_3, 8'h5A);
      chk("async_rst_w", {7'd0, w_d}, 8'h00);
      clr = 1'b1;

      raddr_a = 2'd0;
      wr(OP_LOAD, 2'd0, 8'hFF);
      wr(OP_INC, 2'd0, 8'h00);
      chk("inc_wrap_v", a_d, 8'h00);
      chk("inc_wrap_w", {7'd0, w_d}, 8'h01);
      tick();
      chk("inc_wrap_1cyc", {7'd0, w_d}, 8'h00);
      wr(OP_INC, 2'd0, 8'h00);
      chk("inc_again_v", a_d, 8'h01);
      chk("inc_again_w", {7'd0, w_d}, 8'h00);

      raddr_a = 2'd3;
      wr(OP_LOAD, 2'd3, 8'h00);
      wr(OP_DEC, 2'd3, 8'h00);
      chk("dec_wrap_v", a_d, 8'hFF);
      chk("dec_wrap_w", {7'd0, w_d}, 8'h01);
      wr(OP_LOAD, 2'd3, 8'h7F);
      chk("load_clr_w", {7'd0, w_d}, 8'h00);
      wr(OP_INC, 2'd3, 8'h00);
      chk("inc_7f_v", a_d, 8'h80);
      chk("inc_7f_w", {7'd0, w_d}, 8'h00);

      raddr_a = 2'd1;
      wr(OP_LOAD, 2'd1, 8'h10);
      we = 1'b1; op = OP_LOAD; waddr = 2'd1; wdata = 8'hAA;
      #1;
      chk("byp_on", a_d, 8'hAA);
      chk("byp_off", a_n, 8'h10);
      tick();
      we = 1'b0; op = OP_HOLD;
      #1;
      chk("post_byp", a_d, 8'hAA);
      chk("post_nb", a_n, 8'hAA);
      op = OP_LOAD; wdata = 8'h55;
      #1;
      chk("we0_nobyp", a_d, 8'hAA);
      we = 1'b1; op = OP_INC; raddr_b = 2'd1;
      #1;
      chk("byp_inc_b", b_d, 8'hAB);
      chk("byp_inc_a", a_d, 8'hAB);
      we = 1'b0; op = OP_HOLD;
      #1;

      // DEPTH=3: index 3 is out of range
      wr(OP_LOAD, 2'd3, 8'h77);
      raddr_a = 2'd3; raddr_b = 2'd1;
      #1;
      chk("oor_read", a_3, 8'h00);
      chk("oor_r1", b_3, 8'hAA);
      chk("oor_wrap", {7'd0, w_3}, 8'h00);
      raddr_a = 2'd0; raddr_b = 2'd2;
      #1;
      chk("oor_r0", a_3, 8'h01);
      chk("oor_r2", b_3, 8'h5A);
      chk("in_range4", {8'h00} | (u_dut.rdata_a), 8'h01);

      // reset during a pending INC on reg 0
      @(negedge clk);
      we = 1'b1; op = OP_INC; waddr = 2'd0; raddr_a = 2'd0;
      #1;
      chk("pre_rst_byp", a_d, 8'h02);
      clr = 1'b0;
      #1;
      chk("rst_kills_byp", a_d, 8'h5A);
      tick();
      chk("rst_hold", a_d, 8'h5A);
      @(negedge clk);
      we = 1'b0; op = OP_HOLD;
      clr = 1'b1;
      tick();
      chk("inc_lost", a_d, 8'h5A);
      chk("inc_lost_w", {7'd0, w_d}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
